// File: rtl/metadata_fetch_arbiter.sv
// metadata_fetch_arbiter
// Shares one single-port metadata ROM between N_REQ note-matcher lanes. Each
// lane holds one prefetched 16-bit "next note time" slot; when a lane consumes
// its slot, the lane's next ROM entry is fetched under round-robin arbitration.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal operation: issue at most one ROM read per cycle
//   ST_FLUSH | after rewind: no issues, returning data discarded for
//            | READ_LAT+1 cycles so stale reads drain out of the pipe
module metadata_fetch_arbiter #(
   parameter int          N_REQ    = 37,
   parameter int          IDX_W    = 6,
   parameter int          PTR_W    = 6,
   parameter int          READ_LAT = 2,
   parameter logic [15:0] END_MARK = 16'hFFFF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pause,
   input  logic                   rewind,
   input  logic [N_REQ-1:0]       metadata_request,
   output logic [N_REQ*16-1:0]    metadata_link,
   output logic [N_REQ-1:0]       metadata_available,
   output logic                   mem_en,
   output logic [IDX_W+PTR_W-1:0] mem_addr,
   input  logic [15:0]            mem_dout,
   output logic                   busy
);

   localparam int AW = IDX_W + PTR_W;
   localparam int CW = IDX_W + 1;
   localparam int FW = $clog2(READ_LAT + 2);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [FW-1:0]      flush_cnt;

   logic [PTR_W-1:0]   ptr  [N_REQ];
   logic [15:0]        link [N_REQ];
   logic [N_REQ-1:0]   available;
   logic [N_REQ-1:0]   pending;
   logic [N_REQ-1:0]   done;
   logic [N_REQ-1:0]   eligible;
   logic [IDX_W-1:0]   rr_last;

   logic               issue;
   logic [IDX_W-1:0]   issue_lane;
   logic [CW-1:0]      cand;

   logic               tag_v    [READ_LAT];
   logic [IDX_W-1:0]   tag_lane [READ_LAT];
   logic               tag_any;
   logic               ret_valid;
   logic [IDX_W-1:0]   ret_lane;

   assign ret_valid = tag_v[READ_LAT-1];
   assign ret_lane  = tag_lane[READ_LAT-1];

   // Next-state and round-robin pick: first eligible lane after rr_last, wrapping at N_REQ.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      issue_lane = '0;
      cand       = '0;
      eligible   = ~(available | pending | done);
      case (state)
         ST_RUN: begin
            if (rewind) begin
               state_next = ST_FLUSH;
            end else if (!pause) begin
               for (int k = 0; k < N_REQ; k++) begin
                  cand = {1'b0, rr_last} + CW'(k) + CW'(1);
                  if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
                  if (!issue && eligible[cand[IDX_W-1:0]]) begin
                     issue      = 1'b1;
                     issue_lane = cand[IDX_W-1:0];
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (!rewind && flush_cnt == '0) state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase
   end

   // State register and flush down-counter; a rewind (re)loads the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         flush_cnt <= '0;
      end else begin
         state <= state_next;
         if (rewind)
            flush_cnt <= FW'(READ_LAT);
         else if (state == ST_FLUSH && flush_cnt != '0)
            flush_cnt <= flush_cnt - 1'b1;
      end
   end

   // Registered ROM strobe/address and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_en   <= 1'b0;
         mem_addr <= '0;
         rr_last  <= IDX_W'(N_REQ - 1);
      end else begin
         mem_en <= issue;
         if (issue) begin
            mem_addr <= {issue_lane, ptr[issue_lane]};
            rr_last  <= issue_lane;
         end
      end
   end

   // Lane-tag pipeline, aligned so the last stage coincides with valid mem_dout.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < READ_LAT; k++) begin
            tag_v[k]    <= 1'b0;
            tag_lane[k] <= '0;
         end
      end else begin
         tag_v[0]    <= mem_en;
         tag_lane[0] <= mem_addr[AW-1:PTR_W];
         for (int k = 1; k < READ_LAT; k++) begin
            tag_v[k]    <= tag_v[k-1];
            tag_lane[k] <= tag_lane[k-1];
         end
      end
   end

   // Per-lane slot state: consume, issue bookkeeping and read return.
   // A returning lane is always pending, hence never available or eligible,
   // so consume/issue/return never touch the same lane in one cycle.
   always_ff @(posedge clk) begin
      if (reset || rewind) begin
         available <= '0;
         pending   <= '0;
         done      <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            ptr[i]  <= '0;
            link[i] <= '0;
         end
      end else begin
         available <= available & ~(metadata_request & ~done);
         if (issue) pending[issue_lane] <= 1'b1;
         if (ret_valid && state == ST_RUN) begin
            link[ret_lane]      <= mem_dout;
            available[ret_lane] <= 1'b1;
            pending[ret_lane]   <= 1'b0;
            // End of list, or last owned word: freeze the lane on this entry.
            if (mem_dout == END_MARK || ptr[ret_lane] == '1)
               done[ret_lane] <= 1'b1;
            else
               ptr[ret_lane] <= ptr[ret_lane] + 1'b1;
         end
      end
   end

   // Any read still travelling through the tag pipeline.
   always_comb begin
      tag_any = 1'b0;
      for (int k = 0; k < READ_LAT; k++) tag_any = tag_any | tag_v[k];
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_link
      assign metadata_link[g*16 +: 16] = link[g];
   end

   assign metadata_available = available;
   assign busy               = (state == ST_FLUSH) | mem_en | tag_any;

endmodule

// File: tb/tb_metadata_fetch_arbiter.sv
// Testbench for metadata_fetch_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_metadata_fetch_arbiter;

   localparam int N  = 37;
   localparam int IW = 6;
   localparam int PW = 6;
   localparam int RL = 2;
   localparam int AW = IW + PW;

   logic            clk = 1'b0;
   logic            reset;
   logic            pause;
   logic            rewind;
   logic [N-1:0]    req;
   logic [N*16-1:0] link;
   logic [N-1:0]    avail;
   logic            mem_en;
   logic [AW-1:0]   mem_addr;
   logic [15:0]     mem_dout = 16'h0;
   logic            busy;

   metadata_fetch_arbiter dut (
      .clk                (clk),
      .reset              (reset),
      .pause              (pause),
      .rewind             (rewind),
      .metadata_request   (req),
      .metadata_link      (link),
      .metadata_available (avail),
      .mem_en             (mem_en),
      .mem_addr           (mem_addr),
      .mem_dout           (mem_dout),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   // ROM with READ_LAT = 2: address captured, then data registered.
   logic [15:0]   rom [1 << AW];
   logic [AW-1:0] rd_addr = '0;
   always @(posedge clk) begin
      rd_addr  <= mem_addr;
      mem_dout <= rom[rd_addr];
   end

   // ---------------- reference model (transaction level) ----------------
   typedef struct {
      int lane;
      int due;
   } fl_t;

   fl_t           q[$];
   int            m_ptr [N];
   logic [15:0]   m_link [N];
   logic [N-1:0]  m_avail, m_pend, m_done;
   int            m_rr, m_flush, m_cyc;
   logic          m_en;
   logic [AW-1:0] m_addr;

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [AW-1:0] addr_of(int lane, int p);
      return AW'(lane * (1 << PW) + p);
   endfunction

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_ptr[i]  = 0;
         m_link[i] = 16'h0;
      end
      m_avail = '0;
      m_pend  = '0;
      m_done  = '0;
      q.delete();
      m_en = 1'b0;
   endtask

   task automatic model_reset();
      model_clear();
      m_rr    = N - 1;
      m_flush = 0;
      m_addr  = '0;
   endtask

   task automatic model_step();
      logic [N-1:0] elig;
      int           pick;
      int           ln;
      fl_t          e;
      logic [15:0]  d;
      if (reset) begin
         model_reset();
      end else if (rewind) begin
         model_clear();
         m_flush = RL + 1;
      end else begin
         elig = ~(m_avail | m_pend | m_done);
         pick = -1;
         if (m_flush > 0) begin
            m_flush--;
         end else if (!pause) begin
            for (int k = 1; k <= N; k++) begin
               ln = (m_rr + k) % N;
               if (pick < 0 && elig[ln]) pick = ln;
            end
         end
         for (int i = 0; i < N; i++)
            if (req[i] && m_avail[i] && !m_done[i]) m_avail[i] = 1'b0;
         if (q.size() > 0 && q[0].due == m_cyc) begin
            e = q.pop_front();
            d = rom[addr_of(e.lane, m_ptr[e.lane])];
            m_link[e.lane]  = d;
            m_avail[e.lane] = 1'b1;
            m_pend[e.lane]  = 1'b0;
            if (d == 16'hFFFF || m_ptr[e.lane] == (1 << PW) - 1) m_done[e.lane] = 1'b1;
            else m_ptr[e.lane]++;
         end
         m_en = (pick >= 0);
         if (pick >= 0) begin
            m_addr       = addr_of(pick, m_ptr[pick]);
            m_pend[pick] = 1'b1;
            m_rr         = pick;
            q.push_back('{lane: pick, due: m_cyc + 1 + RL});
         end
      end
      m_cyc++;
   endtask

   task automatic model_check();
      logic [N*16-1:0] flat;
      for (int i = 0; i < N; i++) flat[i*16 +: 16] = m_link[i];
      chk("mdl_mem_en", 640'(mem_en), 640'(m_en));
      chk("mdl_mem_addr", 640'(mem_addr), 640'(m_addr));
      chk("mdl_available", 640'(avail), 640'(m_avail));
      chk("mdl_link", 640'(link), 640'(flat));
      chk("mdl_busy", 640'(busy), 640'((m_flush > 0) || (q.size() > 0)));
   endtask

   // One clock: compare + advance model mid-cycle, return just after next edge.
   task automatic tick();
      @(negedge clk);
      model_check();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset  = 1'b1;
      pause  = 1'b0;
      rewind = 1'b0;
      req    = '0;
      for (int a = 0; a < (1 << AW); a++) rom[a] = 16'h0;
      for (int l = 0; l < N; l++)
         for (int p = 0; p < (1 << PW); p++)
            rom[addr_of(l, p)] = (p == 0) ? 16'(100 + l) : 16'(16'h2000 + l * 64 + p);
      rom[addr_of(3, 1)] = 16'd500;
      rom[addr_of(7, 2)] = 16'hFFFF;
      model_reset();
      m_cyc = 0;
      @(posedge clk);
      #1;
      ticks(2);
      reset = 1'b0;

      // reset values
      chk("rst_available", 640'(avail), 640'(0));
      chk("rst_link", 640'(link), 640'(0));
      chk("rst_mem_en", 640'(mem_en), 640'(0));
      chk("rst_mem_addr", 640'(mem_addr), 640'(0));
      chk("rst_busy", 640'(busy), 640'(0));

      // 1. priming: lanes issued 0..36, one per cycle
      for (int i = 0; i < N; i++) begin
         tick();
         chk("prime_mem_en", 640'(mem_en), 640'(1));
         chk("prime_mem_addr", 640'(mem_addr), 640'(addr_of(i, 0)));
      end
      ticks(3);
      chk("prime_all_avail", 640'(avail), 640'({N{1'b1}}));
      chk("prime_link5", 640'(link[5*16 +: 16]), 640'(105));

      // 2. consume lane 3
      req[3] = 1'b1;
      tick();
      req = '0;
      chk("cons_avail_low", 640'(avail[3]), 640'(0));
      tick();
      chk("cons_mem_en", 640'(mem_en), 640'(1));
      chk("cons_mem_addr", 640'(mem_addr), 640'(addr_of(3, 1)));
      ticks(3);
      chk("cons_link3", 640'(link[3*16 +: 16]), 640'(500));
      chk("cons_avail_high", 640'(avail[3]), 640'(1));

      // 3. round-robin: set rr_last=5, then 0/10/36 together
      req[5] = 1'b1;
      tick();
      req = '0;
      ticks(5);
      req[0]  = 1'b1;
      req[10] = 1'b1;
      req[36] = 1'b1;
      tick();
      req = '0;
      tick();
      chk("rr_first", 640'({mem_en, mem_addr}), 640'({1'b1, addr_of(10, 1)}));
      tick();
      chk("rr_second", 640'({mem_en, mem_addr}), 640'({1'b1, addr_of(36, 1)}));
      tick();
      chk("rr_third", 640'({mem_en, mem_addr}), 640'({1'b1, addr_of(0, 1)}));
      ticks(3);

      // 4. end of list on lane 7
      req[7] = 1'b1;
      tick();
      req = '0;
      ticks(5);
      req[7] = 1'b1;
      tick();
      req = '0;
      ticks(4);
      chk("eol_link7", 640'(link[7*16 +: 16]), 640'(16'hFFFF));
      chk("eol_avail7", 640'(avail[7]), 640'(1));
      req[7] = 1'b1;
      tick();
      req = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("eol_no_issue", 640'(mem_en), 640'(0));
      end
      chk("eol_still_avail", 640'(avail[7]), 640'(1));

      // 5. pause one cycle after request[4]
      req[4] = 1'b1;
      tick();
      req   = '0;
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_no_issue", 640'(mem_en), 640'(0));
      end
      pause = 1'b0;
      tick();
      chk("pause_release", 640'({mem_en, mem_addr}), 640'({1'b1, addr_of(4, 1)}));
      ticks(4);

      // 6. rewind on the cycle lane 9 data returns
      req[9] = 1'b1;
      tick();
      req = '0;
      ticks(3);
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      chk("rew_available", 640'(avail), 640'(0));
      chk("rew_link", 640'(link), 640'(0));
      chk("rew_mem_en", 640'(mem_en), 640'(0));
      chk("rew_busy", 640'(busy), 640'(1));
      for (int i = 0; i < RL + 1; i++) begin
         tick();
         chk("flush_no_issue", 640'(mem_en), 640'(0));
      end
      for (int k = 0; k < N; k++) begin
         tick();
         chk("refill_order", 640'({mem_en, mem_addr}), 640'({1'b1, addr_of((10 + k) % N, 0)}));
      end
      ticks(4);

      // random traffic against the model
      for (int a = 0; a < (1 << AW); a++)
         rom[a] = ($urandom_range(0, 127) == 0) ? 16'hFFFF : 16'($urandom);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 5) == 0);
         pause  = ($urandom_range(0, 9) == 0);
         rewind = ($urandom_range(0, 999) == 0);
         reset  = ($urandom_range(0, 2499) == 0);
         tick();
      end
      req    = '0;
      pause  = 1'b0;
      rewind = 1'b0;
      reset  = 1'b0;
      ticks(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
